// File: rtl/video_ts_pkg.sv
// Shared types and helpers for the tile/sprite render engine.
package video_ts_pkg;

  localparam int X_W   = 9;
  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } ts_state_e;

  // Width code 0..7 selects 8..64 pixels, i.e. 2..16 graphics words.
  function automatic logic [4:0] words_for_xs(input logic [2:0] xs);
    return {1'b0, xs, 1'b0} + 5'd2;
  endfunction

endpackage

// File: rtl/video_ts_render_if.sv
// Render task handshake between the TS processing unit and the renderer.
interface video_ts_render_if;
  logic       tsr_go;
  logic [5:0] tsr_addr;
  logic [8:0] tsr_line;
  logic [7:0] tsr_page;
  logic [8:0] tsr_x;
  logic [2:0] tsr_xs;
  logic       tsr_xf;
  logic [3:0] tsr_pal;
  logic       tsr_rdy;

  modport master (
    output tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    input  tsr_rdy
  );

  modport slave (
    input  tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    output tsr_rdy
  );
endinterface

// File: rtl/video_ts_wfifo.sv
// Small synchronous FIFO holding fetched graphics words until rendered.
module video_ts_wfifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [15:0]              push_data,
  input  logic                     pop,
  output logic [15:0]              pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and occupancy update; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == '0);

endmodule

// File: rtl/video_ts_render.sv
// Tile/sprite renderer: fetches 4bpp bitmap words and writes opaque pixels
// into the TS line buffer.
module video_ts_render
  import video_ts_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  video_ts_render_if.slave    tsr,
  output logic [20:0]         dram_addr,
  output logic                dram_req,
  input  logic                dram_next,
  input  logic [15:0]         dram_rdata,
  output logic [X_W-1:0]      lb_waddr,
  output logic [PIX_W-1:0]    lb_wdata,
  output logic                lb_we
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ts_state_e        state_q, state_d;
  logic             rdy_q, rdy_d;
  logic [5:0]       addr_q, addr_d;
  logic [8:0]       line_q, line_d;
  logic [7:0]       page_q, page_d;
  logic             xf_q, xf_d;
  logic [3:0]       pal_q, pal_d;
  logic [4:0]       nwords_q, nwords_d;
  logic [4:0]       wreq_q, wreq_d;
  logic [6:0]       pix_q, pix_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [15:0]      word_q, word_d;
  logic             wvalid_q, wvalid_d;
  logic [1:0]       sub_q, sub_d;
  logic [X_W-1:0]   lb_waddr_q, lb_waddr_d;
  logic [PIX_W-1:0] lb_wdata_q, lb_wdata_d;
  logic             lb_we_q, lb_we_d;

  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [15:0]      fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;
  logic [4:0]       widx;
  logic [6:0]       col;
  logic [7:0]       page_sum;
  logic [3:0]       nib;

  video_ts_wfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .push      (fifo_push),
    .push_data (dram_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Word request: address of the next word, gated to keep one FIFO slot spare.
  always_comb begin
    widx      = xf_q ? (nwords_q - 5'd1 - wreq_q) : wreq_q;
    col       = {addr_q, 1'b0} + {2'b00, widx};
    page_sum  = page_q + {5'b00000, line_q[8:6]};
    dram_addr = {page_sum, line_q[5:0], col};
    dram_req  = (state_q == ST_FETCH) && (wreq_q < nwords_q) &&
                (fifo_count < CW'(FIFO_DEPTH - 1));
    fifo_push = dram_req && dram_next;
  end

  // Serializer nibble select (flip mirrors the word) and word pop decision.
  always_comb begin
    case (xf_q ? ~sub_q : sub_q)
      2'd0:    nib = word_q[7:4];
      2'd1:    nib = word_q[3:0];
      2'd2:    nib = word_q[15:12];
      default: nib = word_q[11:8];
    endcase
    fifo_pop = (state_q != ST_IDLE) && !fifo_empty && (!wvalid_q || sub_q == 2'd3);
  end

  // Task capture, fetch progress, pixel emission and completion.
  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy_q;
    addr_d     = addr_q;
    line_d     = line_q;
    page_d     = page_q;
    xf_d       = xf_q;
    pal_d      = pal_q;
    nwords_d   = nwords_q;
    wreq_d     = wreq_q;
    pix_d      = pix_q;
    x_d        = x_q;
    word_d     = word_q;
    wvalid_d   = wvalid_q;
    sub_d      = sub_q;
    lb_waddr_d = lb_waddr_q;
    lb_wdata_d = lb_wdata_q;
    lb_we_d    = 1'b0;

    if (start) begin
      state_d  = ST_IDLE;
      rdy_d    = 1'b1;
      wreq_d   = '0;
      pix_d    = '0;
      wvalid_d = 1'b0;
      sub_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tsr.tsr_go && rdy_q) begin
            addr_d   = tsr.tsr_addr;
            line_d   = tsr.tsr_line;
            page_d   = tsr.tsr_page;
            xf_d     = tsr.tsr_xf;
            pal_d    = tsr.tsr_pal;
            nwords_d = words_for_xs(tsr.tsr_xs);
            x_d      = tsr.tsr_x;
            wreq_d   = '0;
            pix_d    = '0;
            sub_d    = '0;
            state_d  = ST_FETCH;
            rdy_d    = 1'b0;
          end
        end
        ST_FETCH: begin
          if (fifo_push) begin
            wreq_d = wreq_q + 5'd1;
            if (wreq_q + 5'd1 == nwords_q) state_d = ST_DRAIN;
          end
        end
        default: ;
      endcase

      if (state_q != ST_IDLE && wvalid_q) begin
        lb_we_d    = (nib != 4'd0);
        lb_wdata_d = {pal_q, nib};
        lb_waddr_d = x_q;
        x_d        = x_q + 9'd1;
        sub_d      = sub_q + 2'd1;
        pix_d      = pix_q + 7'd1;
        if (pix_q == {nwords_q, 2'b00} - 7'd1) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
        end
      end

      if (fifo_pop) begin
        word_d   = fifo_rdata;
        wvalid_d = 1'b1;
      end else if (wvalid_q && sub_q == 2'd3) begin
        wvalid_d = 1'b0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b1;
      addr_q     <= '0;
      line_q     <= '0;
      page_q     <= '0;
      xf_q       <= 1'b0;
      pal_q      <= '0;
      nwords_q   <= 5'd2;
      wreq_q     <= '0;
      pix_q      <= '0;
      x_q        <= '0;
      word_q     <= '0;
      wvalid_q   <= 1'b0;
      sub_q      <= '0;
      lb_waddr_q <= '0;
      lb_wdata_q <= '0;
      lb_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      addr_q     <= addr_d;
      line_q     <= line_d;
      page_q     <= page_d;
      xf_q       <= xf_d;
      pal_q      <= pal_d;
      nwords_q   <= nwords_d;
      wreq_q     <= wreq_d;
      pix_q      <= pix_d;
      x_q        <= x_d;
      word_q     <= word_d;
      wvalid_q   <= wvalid_d;
      sub_q      <= sub_d;
      lb_waddr_q <= lb_waddr_d;
      lb_wdata_q <= lb_wdata_d;
      lb_we_q    <= lb_we_d;
    end
  end

  assign tsr.tsr_rdy = rdy_q;
  assign lb_waddr    = lb_waddr_q;
  assign lb_wdata    = lb_wdata_q;
  assign lb_we       = lb_we_q;

endmodule
